// File: rtl/nvdla_cacc_grp_pkg.sv
// Shared definitions for the CACC ping-pong group controller.
//   - group status encoding (IDLE / RUNNING / PENDING)
//   - controller FSM state type (S_IDLE / S_RUN / S_GAP)
//   - width of the inter-layer gap counter
package nvdla_cacc_grp_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/nvdla_cacc_grp_status.sv
// Per-group status tracker: IDLE -> PENDING (arm) -> RUNNING (launch) -> IDLE (complete).
// An arm strobe is ignored unless the group is IDLE.
// Ports:
//   nvdla_core_clk / nvdla_core_rst : clock, synchronous active-high reset
//   arm, launch, complete           : one-cycle strobes from the group controller
//   status                          : registered 2-bit group status
//   op_en                           : registered enable, high while PENDING or RUNNING
module nvdla_cacc_grp_status
  import nvdla_cacc_grp_pkg::*;
(
  input  logic       nvdla_core_clk,
  input  logic       nvdla_core_rst,
  input  logic       arm,
  input  logic       launch,
  input  logic       complete,
  output logic [1:0] status,
  output logic       op_en
);

  logic [1:0] status_d, status_q;
  logic       op_en_d, op_en_q;

  // Status transitions; each strobe only acts in the state it belongs to.
  always_comb begin
    status_d = status_q;
    case (status_q)
      ST_IDLE:    if (arm)      status_d = ST_PENDING;
      ST_PENDING: if (launch)   status_d = ST_RUNNING;
      ST_RUNNING: if (complete) status_d = ST_IDLE;
      default:                  status_d = ST_IDLE;
    endcase
    op_en_d = (status_d != ST_IDLE);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      status_q <= ST_IDLE;
      op_en_q  <= 1'b0;
    end else begin
      status_q <= status_d;
      op_en_q  <= op_en_d;
    end
  end

  assign status = status_q;
  assign op_en  = op_en_q;

endmodule

// File: rtl/nvdla_cacc_group_ctrl.sv
// CACC ping-pong group consumer: launches armed register groups in pointer order,
// tracks per-group status and advances the hardware group pointer on completion.
// Optional feature macro: NVDLA_CACC_DONE_INTR_EN adds the done_intr[1:0] output.
// Ports:
//   nvdla_core_clk / nvdla_core_rst : clock, synchronous active-high reset
//   producer, op_en_wr              : software group pointer and arm pulse
//   dp_done                         : datapath completion pulse
//   consumer                        : hardware group pointer
//   status_0, status_1, op_en       : per-group status and enable level
//   dp_start, dp_group, busy        : datapath launch pulse, launched group, run flag
//   done_intr (optional)            : per-group completion pulse
module nvdla_cacc_group_ctrl
  import nvdla_cacc_grp_pkg::*;
#(
  parameter int unsigned IDLE_GAP = 2
) (
  input  logic       nvdla_core_clk,
  input  logic       nvdla_core_rst,
  input  logic       producer,
  input  logic       op_en_wr,
  input  logic       dp_done,
  output logic       consumer,
  output logic [1:0] status_0,
  output logic [1:0] status_1,
  output logic [1:0] op_en,
  output logic       dp_start,
  output logic       dp_group,
  output logic       busy
`ifdef NVDLA_CACC_DONE_INTR_EN
  ,
  output logic [1:0] done_intr
`endif
);

  fsm_state_e       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             consumer_d, consumer_q;
  logic             dp_start_d, dp_start_q;
  logic             dp_group_d, dp_group_q;
  logic             busy_d, busy_q;

  logic [1:0] arm_c, launch_c, complete_c;
  logic [1:0] cur_status_c;

  // Arm strobe routed to the group software pointed at.
  assign arm_c = {op_en_wr & producer, op_en_wr & ~producer};

  assign cur_status_c = consumer_q ? status_1 : status_0;

  nvdla_cacc_grp_status u_grp0 (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .arm            (arm_c[0]),
    .launch         (launch_c[0]),
    .complete       (complete_c[0]),
    .status         (status_0),
    .op_en          (op_en[0])
  );

  nvdla_cacc_grp_status u_grp1 (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .arm            (arm_c[1]),
    .launch         (launch_c[1]),
    .complete       (complete_c[1]),
    .status         (status_1),
    .op_en          (op_en[1])
  );

  // Sequencer: only the consumer group may launch; dp_done counts only in S_RUN.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    consumer_d = consumer_q;
    dp_start_d = 1'b0;
    dp_group_d = dp_group_q;
    launch_c   = 2'b00;
    complete_c = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (cur_status_c == ST_PENDING) begin
          launch_c[consumer_q] = 1'b1;
          dp_start_d           = 1'b1;
          dp_group_d           = consumer_q;
          state_d              = S_RUN;
        end
      end
      S_RUN: begin
        if (dp_done) begin
          complete_c[consumer_q] = 1'b1;
          consumer_d             = ~consumer_q;
          if (IDLE_GAP != 0) begin
            cnt_d   = CNT_W'(IDLE_GAP);
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        // Leaving on a count of 1 gives exactly IDLE_GAP cycles in S_GAP.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_RUN);
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      consumer_q <= 1'b0;
      dp_start_q <= 1'b0;
      dp_group_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      consumer_q <= consumer_d;
      dp_start_q <= dp_start_d;
      dp_group_q <= dp_group_d;
      busy_q     <= busy_d;
    end
  end

  assign consumer = consumer_q;
  assign dp_start = dp_start_q;
  assign dp_group = dp_group_q;
  assign busy     = busy_q;

`ifdef NVDLA_CACC_DONE_INTR_EN
  logic [1:0] done_intr_d, done_intr_q;

  assign done_intr_d = complete_c;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) done_intr_q <= 2'b00;
    else                done_intr_q <= done_intr_d;
  end

  assign done_intr = done_intr_q;
`endif

endmodule

// File: tb/tb_nvdla_cacc_group_ctrl.sv
// Self-checking bench for nvdla_cacc_group_ctrl (IDLE_GAP=2 main instance, IDLE_GAP=0 side instance).
// Expected dp_start events are queued by the stimulus and consumed by a negedge monitor.
module tb_nvdla_cacc_group_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT, IDLE_GAP=2
  logic       producer = 1'b0, op_en_wr = 1'b0, dp_done = 1'b0;
  logic       consumer, dp_start, dp_group, busy;
  logic [1:0] status_0, status_1, op_en;
`ifdef NVDLA_CACC_DONE_INTR_EN
  logic [1:0] done_intr;
`endif

  nvdla_cacc_group_ctrl #(.IDLE_GAP(2)) u_dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .producer       (producer),
    .op_en_wr       (op_en_wr),
    .dp_done        (dp_done),
    .consumer       (consumer),
    .status_0       (status_0),
    .status_1       (status_1),
    .op_en          (op_en),
    .dp_start       (dp_start),
    .dp_group       (dp_group),
    .busy           (busy)
`ifdef NVDLA_CACC_DONE_INTR_EN
    ,
    .done_intr      (done_intr)
`endif
  );

  // Side DUT, IDLE_GAP=0
  logic       producer_z = 1'b0, op_en_wr_z = 1'b0, dp_done_z = 1'b0;
  logic       consumer_z, dp_start_z, dp_group_z, busy_z;
  logic [1:0] status_0_z, status_1_z, op_en_z;
`ifdef NVDLA_CACC_DONE_INTR_EN
  logic [1:0] done_intr_z;
`endif

  nvdla_cacc_group_ctrl #(.IDLE_GAP(0)) u_dut_z (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .producer       (producer_z),
    .op_en_wr       (op_en_wr_z),
    .dp_done        (dp_done_z),
    .consumer       (consumer_z),
    .status_0       (status_0_z),
    .status_1       (status_1_z),
    .op_en          (op_en_z),
    .dp_start       (dp_start_z),
    .dp_group       (dp_group_z),
    .busy           (busy_z)
`ifdef NVDLA_CACC_DONE_INTR_EN
    ,
    .done_intr      (done_intr_z)
`endif
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int   cycle;
    logic group;
  } start_t;
  start_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_start(input int c, input logic g);
    start_t s;
    s.cycle = c;
    s.group = g;
    exp_q.push_back(s);
  endtask

  // Monitor: every dp_start pulse of the main DUT must match the next queued expectation.
  always @(negedge clk) begin
    if (!rst && dp_start) begin
      start_t s;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_start: dp_start=1 group=%0d at cycle %0d, none expected", dp_group, cyc);
      end else begin
        s = exp_q.pop_front();
        if (s.cycle != cyc || s.group !== dp_group) begin
          failures++;
          $display("FAIL start_match: got cycle %0d group %0d expected cycle %0d group %0d",
                   cyc, dp_group, s.cycle, s.group);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int t, d;

  initial begin
    step(3);
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_consumer", 32'(consumer), 0);
    chk("rst_status_0", 32'(status_0), 0);
    chk("rst_status_1", 32'(status_1), 0);
    chk("rst_op_en",    32'(op_en),    0);
    chk("rst_dp_start", 32'(dp_start), 0);
    chk("rst_dp_group", 32'(dp_group), 0);
    chk("rst_busy",     32'(busy),     0);

    // Arm group 0: PENDING at t+1, launched at t+2
    producer = 1'b0; op_en_wr = 1'b1; t = cyc;
    push_start(t + 2, 1'b0);
    step(); op_en_wr = 1'b0;
    chk("arm0_status_0", 32'(status_0), 2);
    chk("arm0_op_en",    32'(op_en),    1);
    chk("arm0_busy_pre", 32'(busy),     0);
    step();
    chk("run0_status_0", 32'(status_0), 1);
    chk("run0_busy",     32'(busy),     1);
    chk("run0_dp_group", 32'(dp_group), 0);

    // Arm group 1 while group 0 runs
    producer = 1'b1; op_en_wr = 1'b1;
    step(); op_en_wr = 1'b0;
    chk("arm1_status_1", 32'(status_1), 2);
    chk("arm1_op_en",    32'(op_en),    3);
    step(3);

    // Complete group 0 with a 2-cycle gap: group 1 launches at d+4
    dp_done = 1'b1; d = cyc;
    push_start(d + 4, 1'b1);
    step(); dp_done = 1'b0;
    chk("done0_status_0", 32'(status_0), 0);
    chk("done0_consumer", 32'(consumer), 1);
    chk("done0_status_1", 32'(status_1), 2);
    chk("done0_busy",     32'(busy),     0);
`ifdef NVDLA_CACC_DONE_INTR_EN
    chk("done0_intr", 32'(done_intr), 1);
`endif
    step(2);
    chk("gap_status_1", 32'(status_1), 2);
    step();
    chk("run1_status_1", 32'(status_1), 1);
    chk("run1_busy",     32'(busy),     1);
    chk("run1_dp_group", 32'(dp_group), 1);
    step(3);

    // Re-arm the running group in the same cycle it completes: dropped
    dp_done = 1'b1; producer = 1'b1; op_en_wr = 1'b1;
    step(); dp_done = 1'b0; op_en_wr = 1'b0;
    chk("same_status_1", 32'(status_1), 0);
    chk("same_op_en",    32'(op_en),    0);
    chk("same_consumer", 32'(consumer), 0);
`ifdef NVDLA_CACC_DONE_INTR_EN
    chk("done1_intr", 32'(done_intr), 2);
    step();
    chk("done1_intr_clear", 32'(done_intr), 0);
    step(9);
`else
    step(10);
`endif
    chk("same_idle_status_1", 32'(status_1), 0);
    chk("same_idle_busy",     32'(busy),     0);

    // Arm group 1 only while consumer is 0: waits, never launches
    producer = 1'b1; op_en_wr = 1'b1;
    step(); op_en_wr = 1'b0;
    chk("wait_status_1", 32'(status_1), 2);
    step(50);
    chk("wait_status_1_hold", 32'(status_1), 2);
    chk("wait_busy",          32'(busy),     0);

    // Arm group 0: it launches; then reset mid-run
    producer = 1'b0; op_en_wr = 1'b1; t = cyc;
    push_start(t + 2, 1'b0);
    step(); op_en_wr = 1'b0;
    step();
    chk("pre_rst_busy", 32'(busy), 1);
    step(2);
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("post_rst_consumer", 32'(consumer), 0);
    chk("post_rst_status_0", 32'(status_0), 0);
    chk("post_rst_status_1", 32'(status_1), 0);
    chk("post_rst_op_en",    32'(op_en),    0);
    chk("post_rst_dp_group", 32'(dp_group), 0);
    chk("post_rst_busy",     32'(busy),     0);
    dp_done = 1'b1;
    step(); dp_done = 1'b0;
    chk("stale_done_consumer", 32'(consumer), 0);
    chk("stale_done_status_0", 32'(status_0), 0);
    chk("stale_done_busy",     32'(busy),     0);
    step(10);

    // IDLE_GAP=0 instance: next launch at d+2
    producer_z = 1'b0; op_en_wr_z = 1'b1;
    step(); op_en_wr_z = 1'b0;
    step();
    chk("z_start0",    32'(dp_start_z), 1);
    chk("z_group0",    32'(dp_group_z), 0);
    producer_z = 1'b1; op_en_wr_z = 1'b1;
    step(); op_en_wr_z = 1'b0;
    step(2);
    dp_done_z = 1'b1;
    step(); dp_done_z = 1'b0;
    chk("z_done_consumer", 32'(consumer_z), 1);
    chk("z_done_nostart",  32'(dp_start_z), 0);
    chk("z_done_status_1", 32'(status_1_z), 2);
`ifdef NVDLA_CACC_DONE_INTR_EN
    chk("z_done_intr", 32'(done_intr_z), 1);
`endif
    step();
    chk("z_start1", 32'(dp_start_z), 1);
    chk("z_group1", 32'(dp_group_z), 1);
    step();
    chk("z_start_pulse", 32'(dp_start_z), 0);

    step(5);
    chk("sb_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nvdla_cacc_group_ctrl.md
# nvdla_cacc_group_ctrl

Hardware-side consumer of the CACC ping-pong register groups. Software selects a group through `producer` and arms it with an op-enable write. This block queues the armed groups in pointer order and launches the datapath on each one. It tracks per-group IDLE/PENDING/RUNNING status and advances `consumer` on completion, and it sits between the CACC single-register block and the CACC datapath launch logic.

## Interface
Parameters:
- `IDLE_GAP`, default 2: quiet cycles enforced between `dp_done` and the next `dp_start`; legal range 0..15.

Ports:
- `nvdla_core_clk`  in  1  core clock; the only clock.
- `nvdla_core_rst`  in  1  reset, synchronous, active-high.
- `producer`  in  1  software group pointer from the single-register block.
- `op_en_wr`  in  1  one-cycle pulse: software wrote OP_ENABLE=1 to the group indexed by `producer` in the same cycle.
- `dp_done`  in  1  one-cycle pulse: datapath finished the running layer.
- `consumer`  out  1  hardware group pointer, fed back to the single-register block.
- `status_0`  out  2  group 0 status.
- `status_1`  out  2  group 1 status.
- `op_en`  out  2  per-group enable level; high while that group is PENDING or RUNNING.
- `dp_start`  out  1  one-cycle launch pulse to the datapath.
- `dp_group`  out  1  group being launched or running; valid while `busy`.
- `busy`  out  1  high while in S_RUN.

## Operation
- Status encoding: IDLE=2'd0, RUNNING=2'd1, PENDING=2'd2. Code 2'd3 is never produced.
- Arm: `op_en_wr` with status[`producer`]==IDLE moves that group to PENDING. The write is ignored if the group is PENDING or RUNNING; there is no error output.
- FSM states are S_IDLE, S_RUN and S_GAP.
  - S_IDLE: if status[`consumer`]==PENDING, pulse `dp_start`, set `dp_group`=`consumer` and status->RUNNING, then go to S_RUN. A PENDING group that is not `consumer` waits.
  - S_RUN: on `dp_done`, status[`consumer`]->IDLE and `consumer` toggles.
    - IDLE_GAP>0: load the counter with IDLE_GAP and go to S_GAP.
    - IDLE_GAP==0: go to S_IDLE.
  - S_GAP: decrement the counter each cycle; go to S_IDLE when the counter reaches 1.
- `dp_done` outside S_RUN is ignored.
- `op_en_wr` and `dp_done` in the same cycle for the same group: the group is RUNNING, so the write is dropped and the group ends IDLE.
- `op_en_wr` for the other group during S_RUN or S_GAP is accepted; that group goes to PENDING.
- `consumer` wraps 1->0.
- `producer` is never modified here.

## Timing
- All outputs are registered.
- Reset values: `consumer`=0, `status_0`=`status_1`=0, `op_en`=0, `dp_start`=0, `dp_group`=0, `busy`=0. Internal reset values: FSM=S_IDLE, counter=0.
- `op_en_wr` at cycle t: status becomes PENDING at t+1. If the FSM is in S_IDLE and the group is `consumer`, `dp_start`=1 and status=RUNNING at t+2.
- `dp_done` at cycle d:
  - status IDLE and `consumer` toggled at d+1.
  - S_IDLE reached at d+1+IDLE_GAP.
  - Earliest next `dp_start` is at d+2+IDLE_GAP (d+2 when IDLE_GAP=0).
- Reset asserted at any point, including mid-run or mid-gap: all state returns to reset values on the next edge. In-flight layers are abandoned, and a later `dp_done` is ignored.

## Configuration
- `NVDLA_CACC_DONE_INTR_EN` defined: adds output `done_intr` [1:0]. Bit g pulses for one cycle at d+1 when group g completes. Reset value is 0.
- Macro undefined: the `done_intr` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `nvdla_cacc_grp_pkg` holds:
  - the status encoding constants (IDLE/RUNNING/PENDING);
  - the FSM state typedef (S_IDLE/S_RUN/S_GAP);
  - the counter width constant (4).
- Sub-module `nvdla_cacc_grp_status` is instantiated twice, one per group.
  - Inputs: arm, launch and complete strobes.
  - Outputs: the 2-bit status and `op_en` bit.
  - It owns the IDLE->PENDING->RUNNING->IDLE transitions and the ignore-when-busy rule.
- The top level owns the FSM, the gap counter, `consumer`, and the `dp_*` outputs.

## Test plan
- Reset, then `producer`=0 and `op_en_wr` at t -> `status_0`=2 at t+1; `dp_start`=1, `dp_group`=0, `status_0`=1 at t+2; `busy`=1 from t+2.
- Arm group 0, then group 1 while group 0 runs; `dp_done` at d with IDLE_GAP=2 -> `status_0`=0 and `consumer`=1 at d+1; `dp_start` with `dp_group`=1 exactly at d+4.
- Arm group 1 only while `consumer`=0 -> `status_1`=2 holds and `dp_start` never asserts over 50 cycles.
- `op_en_wr` to the RUNNING group in the same cycle as `dp_done` -> group ends IDLE with `op_en` bit 0; no new start.
- Assert `nvdla_core_rst` during S_RUN, then pulse `dp_done` -> all outputs 0 the cycle after reset; `consumer` stays 0.
- With `NVDLA_CACC_DONE_INTR_EN`: group 1 completes at d -> `done_intr`=2'b10 at d+1 only; IDLE_GAP=0 run gives next `dp_start` at d+2.
